// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if
// MEM-stage load/store bus between the CPU pipeline and the data-memory
// responder.
//   mem_write   : store request this cycle
//   mem_read    : load request this cycle
//   dm_ctrl     : access kind (000 word, 001 half, 010 half-unsigned,
//                 011 byte, 100 byte-unsigned)
//   addr_in     : byte address of the access
//   wdata_in    : store data, value held in the low bits
//   rdata_out   : aligned, extended load data
//   rdata_valid : rdata_out carries a load result this cycle
// ----------------------------------------------------------------------------
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              mem_write;
    logic              mem_read;
    logic [2:0]        dm_ctrl;
    logic [ADDR_W-1:0] addr_in;
    logic [31:0]       wdata_in;
    logic [31:0]       rdata_out;
    logic              rdata_valid;

    modport master (
        output mem_write, mem_read, dm_ctrl, addr_in, wdata_in,
        input  rdata_out, rdata_valid
    );

    modport slave (
        input  mem_write, mem_read, dm_ctrl, addr_in, wdata_in,
        output rdata_out, rdata_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Memory side of the MEM-stage load/store interface. Stores are steered onto
// byte lanes with per-lane write enables; loads are read in one cycle and
// aligned plus sign/zero extended on the way out. After reset the array is
// zero-filled one word per cycle while busy is high. Misaligned accesses and
// unknown dm_ctrl codes are dropped and flagged.
// Ports:
//   clk        : clock, all state on posedge
//   rstn       : asynchronous reset, active-high (1 = reset)
//   bus        : dmem_if.slave load/store bus
//   err_clr    : clears err_sticky and err_addr
//   busy       : zero-fill in progress, requests ignored
//   err_sticky : a misaligned/illegal access has occurred
//   err_addr   : address of the first erroneous access since the last clear
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    dmem_if.slave             bus,
    input  logic              err_clr,
    output logic              busy,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] init_cnt;

    logic [3:0][7:0]  mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             ctrl_ok, aligned, req, err_hit, st_go, ld_go;
    logic [3:0]       st_wea;
    logic [3:0][7:0]  st_data;

    logic [31:0]      rd_word_p1;
    logic [1:0]       rd_off_p1;
    logic [2:0]       rd_ctrl_p1;
    logic             vld_p1;
    logic             rd_seen;

    function automatic logic [3:0] lane_wea(input logic [2:0] ctrl, input logic [1:0] a);
        case (ctrl)
            3'b000:         lane_wea = 4'b1111;
            3'b001, 3'b010: lane_wea = a[1] ? 4'b1100 : 4'b0011;
            default:        lane_wea = 4'b0001 << a;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] ctrl, input logic [31:0] w);
        case (ctrl)
            3'b000:         lane_data = w;
            3'b001, 3'b010: lane_data = {2{w[15:0]}};
            default:        lane_data = {4{w[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [2:0] ctrl);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        case (ctrl)
            3'b000:  load_extract = w;
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b010:  load_extract = {16'b0, h};
            3'b011:  load_extract = {{24{b[7]}}, b};
            default: load_extract = {24'b0, b};
        endcase
    endfunction

    // Request decode: high address bits above the word index are ignored.
    assign idx = bus.addr_in[IDX_W+1:2];
    assign off = bus.addr_in[1:0];

    always_comb begin
        ctrl_ok = (bus.dm_ctrl <= 3'b100);
        case (bus.dm_ctrl)
            3'b000:         aligned = (off == 2'b00);
            3'b001, 3'b010: aligned = ~off[0];
            default:        aligned = 1'b1;
        endcase
        req     = (state == S_RUN) && (bus.mem_write || bus.mem_read);
        err_hit = req && !(ctrl_ok && aligned);
        st_go   = req && ctrl_ok && aligned && bus.mem_write;
        // A simultaneous read and write performs only the store.
        ld_go   = req && ctrl_ok && aligned && bus.mem_read && !bus.mem_write;
        st_wea  = lane_wea(bus.dm_ctrl, off);
        st_data = lane_data(bus.dm_ctrl, bus.wdata_in);
    end

    // Zero-fill FSM: one word per cycle, busy drops after the last word.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state    <= S_INIT;
            init_cnt <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

    // ---- stage p0 -> p1: array write / array read ----
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= '0;
        end else if (st_go) begin
            for (int l = 0; l < 4; l++) begin
                if (st_wea[l]) mem[idx][l] <= st_data[l];
            end
        end
        if (ld_go) begin
            rd_word_p1 <= mem[idx];
            rd_off_p1  <= off;
            rd_ctrl_p1 <= bus.dm_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            vld_p1     <= 1'b0;
            rd_seen    <= 1'b0;
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else begin
            vld_p1 <= ld_go;
            if (ld_go) rd_seen <= 1'b1;
            // Clear wins over a same-cycle error; that error is lost.
            if (err_clr) begin
                err_sticky <= 1'b0;
                err_addr   <= '0;
            end else if (err_hit) begin
                err_sticky <= 1'b1;
                if (!err_sticky) err_addr <= bus.addr_in;
            end
        end
    end

    // ---- stage p1: alignment and extension ----
    // Read registers only move on a legal load, so the output holds between
    // loads; rd_seen forces zero until the first load after reset.
    assign bus.rdata_out   = rd_seen ? load_extract(rd_word_p1, rd_off_p1, rd_ctrl_p1) : 32'h0;
    assign bus.rdata_valid = vld_p1;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rstn;
    logic        err_clr;
    logic        busy;
    logic        err_sticky;
    logic [31:0] err_addr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(32)) bus ();

    dmem_responder #(.DEPTH_WORDS(16), .ADDR_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .err_clr    (err_clr),
        .busy       (busy),
        .err_sticky (err_sticky),
        .err_addr   (err_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request cycle; outputs of that edge are visible on return.
    task automatic req(input logic we, input logic re, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bus.mem_write = we;
        bus.mem_read  = re;
        bus.dm_ctrl   = ctrl;
        bus.addr_in   = addr;
        bus.wdata_in  = wdata;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] exp);
        req(1'b0, 1'b1, ctrl, addr, 32'h0);
        check_eq({tag, "_vld"}, {31'b0, bus.rdata_valid}, 32'h1);
        check_eq(tag, bus.rdata_out, exp);
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!busy) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rstn          = 1'b1;
        err_clr       = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.dm_ctrl   = 3'b000;
        bus.addr_in   = 32'h0;
        bus.wdata_in  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'h1);
        check_eq("rst_vld", {31'b0, bus.rdata_valid}, 32'h0);
        check_eq("rst_rdata", bus.rdata_out, 32'h0);
        check_eq("rst_err", {31'b0, err_sticky}, 32'h0);
        check_eq("rst_err_addr", err_addr, 32'h0);

        // Zero-fill length, then every word reads zero back-to-back
        rstn = 1'b0;
        wait_init(n);
        check_eq("init_cycles", n, 32'd16);
        for (int i = 0; i < 16; i++) load_chk("zero_lw", 3'b000, i * 4, 32'h0);

        // Store then immediate load, then output hold
        req(1'b1, 1'b0, 3'b000, 32'h8, 32'h12345678);
        load_chk("sw_lw", 3'b000, 32'h8, 32'h12345678);
        @(posedge clk);
        #1;
        check_eq("hold_vld", {31'b0, bus.rdata_valid}, 32'h0);
        check_eq("hold_rdata", bus.rdata_out, 32'h12345678);

        // Byte and half lanes
        req(1'b1, 1'b0, 3'b011, 32'h13, 32'h000000A5);
        load_chk("lb", 3'b011, 32'h13, 32'hFFFFFFA5);
        load_chk("lbu", 3'b100, 32'h13, 32'h000000A5);
        load_chk("lw_b3", 3'b000, 32'h10, 32'hA5000000);
        req(1'b1, 1'b0, 3'b001, 32'h12, 32'h00008001);
        load_chk("lh", 3'b001, 32'h12, 32'hFFFF8001);
        load_chk("lhu", 3'b010, 32'h12, 32'h00008001);
        load_chk("lw_h1", 3'b000, 32'h10, 32'h80010000);

        // Misaligned accesses and error capture
        req(1'b1, 1'b0, 3'b001, 32'h21, 32'h0000BEEF);
        check_eq("mis_sh_vld", {31'b0, bus.rdata_valid}, 32'h0);
        check_eq("mis_sh_err", {31'b0, err_sticky}, 32'h1);
        check_eq("mis_sh_addr", err_addr, 32'h21);
        load_chk("mis_nowrite", 3'b000, 32'h20, 32'h0);
        req(1'b0, 1'b1, 3'b000, 32'h26, 32'h0);
        check_eq("mis_lw_vld", {31'b0, bus.rdata_valid}, 32'h0);
        check_eq("err_addr_keep", err_addr, 32'h21);
        load_chk("lw_24", 3'b000, 32'h24, 32'h0);
        check_eq("err_addr_keep2", err_addr, 32'h21);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_eq("clr_err", {31'b0, err_sticky}, 32'h0);
        check_eq("clr_addr", err_addr, 32'h0);
        err_clr = 1'b1;
        req(1'b0, 1'b1, 3'b000, 32'h1, 32'h0);
        err_clr = 1'b0;
        check_eq("clr_prio_err", {31'b0, err_sticky}, 32'h0);
        check_eq("clr_prio_addr", err_addr, 32'h0);

        // Simultaneous read/write, then illegal dm_ctrl
        req(1'b1, 1'b1, 3'b000, 32'h4, 32'hDEADBEEF);
        check_eq("rw_vld", {31'b0, bus.rdata_valid}, 32'h0);
        load_chk("rw_lw", 3'b000, 32'h4, 32'hDEADBEEF);
        load_chk("lb_b3", 3'b011, 32'h7, 32'hFFFFFFDE);
        load_chk("lbu_b1", 3'b100, 32'h5, 32'h000000BE);
        load_chk("lhu_hi", 3'b010, 32'h6, 32'h0000DEAD);
        req(1'b0, 1'b1, 3'b110, 32'h4, 32'h0);
        check_eq("bad_ctrl_vld", {31'b0, bus.rdata_valid}, 32'h0);
        check_eq("bad_ctrl_err", {31'b0, err_sticky}, 32'h1);
        check_eq("bad_ctrl_addr", err_addr, 32'h4);

        // Reset mid-init restarts the fill; stores before/during init are gone
        req(1'b1, 1'b0, 3'b000, 32'hC, 32'h55667788);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        check_eq("rst2_err", {31'b0, err_sticky}, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        req(1'b1, 1'b0, 3'b000, 32'h8, 32'hCAFEF00D);
        check_eq("init_drop_err", {31'b0, err_sticky}, 32'h0);
        req(1'b0, 1'b1, 3'b000, 32'h8, 32'h0);
        check_eq("init_drop_vld", {31'b0, bus.rdata_valid}, 32'h0);
        req(1'b0, 1'b1, 3'b000, 32'h2, 32'h0);
        check_eq("init_no_err", {31'b0, err_sticky}, 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst3_busy", {31'b0, busy}, 32'h1);
        rstn = 1'b0;
        wait_init(n);
        check_eq("reinit_cycles", n, 32'd16);
        load_chk("pre_rst_st", 3'b000, 32'hC, 32'h0);
        load_chk("init_st_drop", 3'b000, 32'h8, 32'h0);
        load_chk("pre_rst_4", 3'b000, 32'h4, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
